// File: rtl/game_pkg.sv
// Shared 2048 game definitions: direction encoding, repeat FSM states and
// 25 MHz-derived default timing constants used by debouncer, input and game FSM.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_t;

  localparam int CLK_HZ            = 25_000_000;
  localparam int DEF_REPEAT_DELAY  = 12_500_000;
  localparam int DEF_REPEAT_PERIOD = 5_000_000;

endpackage

// File: rtl/move_fifo.sv
// Parametric synchronous FIFO for move commands; a push into a full queue is
// accepted when a pop happens in the same cycle.
module move_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// Turns debounced direction levels into queued move commands (valid/ready).
// Define MOVE_AUTOREPEAT_EN to add hold-to-repeat; otherwise only presses count.
module move_input_ctrl
  import game_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       overflow
);

  logic [3:0] lvl;
  logic [3:0] prev;
  logic [3:0] rise;
  logic       armed;
  logic       edge_ev;
  logic [1:0] edge_dir;
  logic       ev;
  logic [1:0] ev_dir;
  logic       full;
  logic       empty;

  assign lvl  = {btn_up, btn_down, btn_left, btn_right};
  // The first cycle after reset only samples levels so held buttons stay silent.
  assign rise = armed ? (lvl & ~prev) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= lvl;
      armed <= 1'b1;
    end
  end

  always_comb begin
    edge_ev  = |rise;
    edge_dir = DIR_RIGHT;
    if (rise[3])      edge_dir = DIR_UP;
    else if (rise[2]) edge_dir = DIR_DOWN;
    else if (rise[1]) edge_dir = DIR_LEFT;
  end

`ifdef MOVE_AUTOREPEAT_EN
  rpt_state_t       rpt_state;
  logic [CNT_W-1:0] rpt_cnt;
  logic [1:0]       rpt_dir;
  logic             one_held;
  logic             level_chg;
  logic             rpt_ev;

  assign one_held  = $onehot(lvl);
  assign level_chg = (lvl != prev);
  assign rpt_ev    = one_held && !level_chg &&
                     (((rpt_state == RPT_DELAY)  && (rpt_cnt == CNT_W'(REPEAT_DELAY - 1))) ||
                      ((rpt_state == RPT_PERIOD) && (rpt_cnt == CNT_W'(REPEAT_PERIOD - 1))));

  // A fresh single-button edge restarts tracking even though the level changed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
      rpt_dir   <= DIR_UP;
    end else if (edge_ev && one_held) begin
      rpt_state <= RPT_DELAY;
      rpt_cnt   <= '0;
      rpt_dir   <= edge_dir;
    end else if (level_chg || !one_held) begin
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
    end else begin
      case (rpt_state)
        RPT_DELAY: begin
          if (rpt_ev) begin
            rpt_state <= RPT_PERIOD;
            rpt_cnt   <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + CNT_W'(1);
          end
        end
        RPT_PERIOD: rpt_cnt <= rpt_ev ? '0 : rpt_cnt + CNT_W'(1);
        default:    rpt_cnt <= '0;
      endcase
    end
  end

  assign ev     = edge_ev || rpt_ev;
  assign ev_dir = edge_ev ? edge_dir : rpt_dir;
`else
  assign ev     = edge_ev;
  assign ev_dir = edge_dir;
`endif

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ev),
    .pop   (move_ready),
    .din   (ev_dir),
    .dout  (move_dir),
    .full  (full),
    .empty (empty)
  );

  assign move_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= ev && full && !(move_valid && move_ready);
  end

endmodule

// File: doc/move_input_ctrl.md
# move_input_ctrl

Converts the four debounced direction-button levels into a queue of discrete move commands for the 2048 game engine. It sits directly downstream of the four per-button debouncers and upstream of the board-update FSM. Rising edges become move events, and simultaneous presses are resolved by fixed priority. Events are buffered in a small FIFO and delivered over a valid/ready handshake, with an optional auto-repeat while a button is held.

## Interface
- `FIFO_DEPTH`, default 4: command queue depth; power of two, ≥2.
- `REPEAT_DELAY`, default 12500000: cycles from press to first repeat (500 ms at 25 MHz).
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeats (200 ms).
- `CNT_W`, default 24: repeat counter width; must hold `max(REPEAT_DELAY, REPEAT_PERIOD)`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: synchronous, active-low; clock `clk`.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced levels, already synchronous to `clk`.
- `move_valid`  out  1  queue head holds a command.
- `move_dir`  out  2  head direction (encoding in Structure).
- `move_ready`  in  1  consumer accepts head.
- `overflow`  out  1  one-cycle pulse when an event is dropped because the queue is full.

## Operation
**Edge detection**
- A previous-level register per button; reset value 0.
- `rise = btn & ~prev`.

**Arbitration**
- If several buttons rise in the same cycle, exactly one event is generated.
- Priority: up > down > left > right. Losers are discarded silently and do not assert `overflow`.

**FIFO**
- Write pointer, read pointer and occupancy count.
- Push when an event exists and the queue is not full.
- Pop on `move_valid && move_ready`.
- Full with simultaneous pop: push is accepted and occupancy is unchanged.
- Full without pop: event dropped, `overflow` high for one cycle.
- Empty: `move_ready` is ignored. `move_dir` holds the last-read slot and is don't-care.
- Pointers wrap modulo `FIFO_DEPTH`.

**Auto-repeat** (only with the macro; see Configuration)
- Tracks the direction of the last accepted edge event while exactly one button is held.
- The counter starts at 0 on that edge.
- At `REPEAT_DELAY` it emits a repeat event of the same direction and reloads to 0 in PERIOD phase. Each `REPEAT_PERIOD` after that emits another.
- The repeat is cleared when any button level changes or more than one button is held; the counter returns to idle.
- Repeat events go through the same push/overflow path. If an edge event and a repeat event coincide, the edge event wins.
- Repeat FSM states:
  - IDLE: no tracked button.
  - DELAY: counting `REPEAT_DELAY`.
  - PERIOD: counting `REPEAT_PERIOD`.
- Transitions: IDLE→DELAY on an accepted-or-dropped single-button edge; DELAY→PERIOD on the first repeat; any state→IDLE on a clear condition.

## Timing
- Reset values: `move_valid`=0, `move_dir`=0, `overflow`=0. Queue is empty, `prev`=0, repeat FSM in IDLE.
- A button that is high during reset produces no event after reset. On the first post-reset cycle, `prev` is loaded without an edge.
- Latency: a level first seen high at edge k is pushed at edge k. `move_valid` is high after edge k, so it is visible one cycle after the input rises.
- A pop at edge k removes the head. The next entry (if any) is presented after edge k.
- Back-to-back: one push and one pop per cycle, sustained.
- `overflow` is registered and asserts the cycle after the dropped event.
- Reset mid-operation flushes the queue and repeat state within the same clock edge.

## Configuration
- `MOVE_AUTOREPEAT_EN` defined: repeat counter and FSM are present as described; `REPEAT_DELAY`, `REPEAT_PERIOD` and `CNT_W` apply.
- Not defined: only rising edges generate events. Holding a button produces exactly one command. No counter logic is synthesized; the parameters remain declared but unused.

## Structure
- Shared package `game_pkg` holds:
  - the 2-bit direction encoding: `DIR_UP`=0, `DIR_RIGHT`=1, `DIR_DOWN`=2, `DIR_LEFT`=3;
  - the 25 MHz-derived default timing constants, shared with the debouncer and game FSM.
- One sub-module, `move_fifo`: parametric sync FIFO with push/pop/full/empty and same-cycle push-when-full-with-pop.

## Test plan
Bench parameters: `FIFO_DEPTH`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.

- **Reset/hold:** `btn_left` high through reset, stays high 50 cycles, no macro → `move_valid` stays 0. Release and press again → exactly one command, `move_dir`=3.
- **Single press:** `btn_up` rises at cycle 10 with `move_ready`=0 → `move_valid`=1 from cycle 11 with `move_dir`=0. Set `move_ready`=1 at cycle 15 → `move_valid`=0 at cycle 16.
- **Simultaneous rise:** `btn_down` and `btn_right` rise in the same cycle → one command, `move_dir`=2, no `overflow`.
- **Overflow:** `move_ready`=0, 5 distinct presses → 4 queued (order preserved), 5th asserts `overflow` for one cycle. A 6th press coinciding with a pop is accepted.
- **Auto-repeat** (`MOVE_AUTOREPEAT_EN`, `move_ready`=1): hold `btn_right` for 60 cycles → commands at press +0, +20, +28, +36, +44, +52, all `move_dir`=1. Pressing `btn_up` mid-hold stops repeats and yields one `DIR_UP`.
- **Reset mid-queue:** 3 entries queued, `rst_n`=0 for one cycle → `move_valid`=0 next cycle, and the next press yields a single fresh command.
